// File: rtl/qc_parity_enc.sv
// Quasi-cyclic LDPC parity encoder with identity parity part: each info sub-block
// is rotated by S[r][c] and folded into acc[r]. Parity sub-blocks stream out once
// the last info sub-block has been absorbed.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, and a raised valid holds its payload until the transfer.
module qc_parity_enc #(
  parameter int D     = 5,
  parameter int mtx_w = 8,
  parameter int KB    = 4,
  parameter int MB    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MB*KB*mtx_w-1:0] shift_tbl,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [D-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D-1:0]           out_data,
  output logic                   out_last,
  output logic                   tbl_err
);

  localparam int RW = (MB > 1) ? $clog2(MB) : 1;
  localparam int CW = (KB > 1) ? $clog2(KB) : 1;
  localparam logic [mtx_w-1:0] NULL_S = '1;
  localparam logic [mtx_w-1:0] D_S    = mtx_w'(D);
  localparam logic [RW-1:0]    ROW_LAST = RW'(MB - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(KB - 1);

  typedef enum logic [1:0] {S_IN, S_UPD, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [RW-1:0]    oidx_q, oidx_d;
  logic [CW-1:0]    col_q, col_d;
  logic [D-1:0]     u_q, u_d;
  logic [D-1:0]     acc_q [MB];
  logic [D-1:0]     acc_d [MB];
  logic             err_q, err_d;

  logic [mtx_w-1:0] s_cur;
  logic             null_s;
  logic             bad_s;
  logic [D-1:0]     term;

  // Rotation datapath: right-rotating the duplicated word gives rot(x,s)[i] = x[(i+s) mod D].
  always_comb begin
    s_cur  = shift_tbl[(int'(row_q) * KB + int'(col_q)) * mtx_w +: mtx_w];
    null_s = (s_cur == NULL_S);
    bad_s  = !null_s && (s_cur >= D_S);
    term   = (null_s || bad_s) ? '0 : D'({u_q, u_q} >> s_cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IN;
      row_q   <= '0;
      col_q   <= '0;
      oidx_q  <= '0;
      u_q     <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MB; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      oidx_q  <= oidx_d;
      u_q     <= u_d;
      err_q   <= err_d;
      for (int i = 0; i < MB; i++) acc_q[i] <= acc_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    oidx_d  = oidx_q;
    u_d     = u_q;
    err_d   = err_q;
    for (int i = 0; i < MB; i++) acc_d[i] = acc_q[i];

    case (state_q)
      S_IN: begin
        if (in_valid) begin
          u_d     = in_data;
          row_d   = '0;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        // Column 0 overwrites, so accumulators never need clearing between frames.
        acc_d[row_q] = (col_q == '0) ? term : (acc_q[row_q] ^ term);
        if (bad_s) err_d = 1'b1;
        if (row_q == ROW_LAST) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = S_OUT;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = S_IN;
          end
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (oidx_q == ROW_LAST) begin
            oidx_d  = '0;
            state_d = S_IN;
          end else begin
            oidx_d = oidx_q + RW'(1);
          end
        end
      end
      default: state_d = S_IN;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state_q == S_IN);
    out_valid = !rst && (state_q == S_OUT);
    out_data  = out_valid ? acc_q[oidx_q] : '0;
    out_last  = out_valid && (oidx_q == ROW_LAST);
    tbl_err   = !rst && err_q;
  end

endmodule

// File: tb/tb_qc_parity_enc.sv
// Self-checking bench for qc_parity_enc: directed frames with literal expected parity,
// plus randomised frames checked against an independent index-based rotation model.
module tb_qc_parity_enc;

  localparam int D     = 5;
  localparam int MTX_W = 8;
  localparam int KB    = 4;
  localparam int MB    = 2;
  localparam int TMO   = 200;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [MB*KB*MTX_W-1:0] shift_tbl = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [D-1:0]           in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [D-1:0]           out_data;
  logic                   out_last;
  logic                   tbl_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [D-1:0] exp_q[$];
  logic [D-1:0] u_frame [KB];

  qc_parity_enc #(.D(D), .mtx_w(MTX_W), .KB(KB), .MB(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift_tbl (shift_tbl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .tbl_err   (tbl_err)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [D-1:0] model_rot(input logic [D-1:0] x, input int s);
    logic [D-1:0] r;
    r = '0;
    if (s < D) begin
      for (int i = 0; i < D; i++) r[i] = x[(i + s) % D];
    end
    return r;
  endfunction

  function automatic int get_entry(input int r, input int c);
    return int'(shift_tbl[(r*KB + c)*MTX_W +: MTX_W]);
  endfunction

  task automatic set_entry(input int r, input int c, input int v);
    shift_tbl[(r*KB + c)*MTX_W +: MTX_W] = MTX_W'(v);
  endtask

  task automatic push_model;
    logic [D-1:0] p;
    for (int r = 0; r < MB; r++) begin
      p = '0;
      for (int c = 0; c < KB; c++) p ^= model_rot(u_frame[c], get_entry(r, c));
      exp_q.push_back(p);
    end
  endtask

  task automatic load_basic;
    set_entry(0, 0, 0);   set_entry(0, 1, 1); set_entry(0, 2, 2); set_entry(0, 3, 3);
    set_entry(1, 0, 255); set_entry(1, 1, 4); set_entry(1, 2, 0); set_entry(1, 3, 0);
    for (int c = 0; c < KB; c++) u_frame[c] = 5'b00001;
  endtask

  // ---------------- drivers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sub(input logic [D-1:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < TMO) begin
      tick();
      t++;
    end
    if (t >= TMO) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never high within %0d cycles", TMO);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame;
    for (int c = 0; c < KB; c++) send_sub(u_frame[c]);
  endtask

  // Collects MB parity sub-blocks, optionally with random backpressure.
  task automatic recv_frame(input bit rand_bp);
    int t;
    logic [D-1:0] e;
    for (int k = 0; k < MB; k++) begin
      t = 0;
      forever begin
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) break;
        if (t >= TMO) break;
        tick();
        t++;
      end
      n_tests++;
      if (t >= TMO) begin
        n_fail++;
        $display("FAIL recv_timeout: beat %0d out_valid=%0b after %0d cycles", k, out_valid, t);
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== e || out_last !== (k == MB - 1)) begin
          n_fail++;
          $display("FAIL parity_beat%0d: got data=%h last=%0b, expected data=%h last=%0b",
                   k, out_data, out_last, e, (k == MB - 1));
        end
        tick();
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, got, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    check_bit("reset_in_ready", in_ready, 1'b0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_out_last", out_last, 1'b0);
    check_bit("reset_tbl_err", tbl_err, 1'b0);
    n_tests++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h expected 00", out_data);
    end
    rst = 1'b0;
    #1;
    check_bit("post_reset_in_ready", in_ready, 1'b1);
  endtask

  task automatic test_basic;
    load_basic();
    exp_q.push_back(5'h1D);
    exp_q.push_back(5'h02);
    send_frame();
    recv_frame(1'b0);
    check_bit("basic_tbl_err", tbl_err, 1'b0);
  endtask

  task automatic test_timing;
    load_basic();
    exp_q.push_back(5'h1D);
    exp_q.push_back(5'h02);
    out_ready = 1'b0;
    send_sub(u_frame[0]);
    check_bit("timing_ready_T1", in_ready, 1'b0);
    tick();
    check_bit("timing_ready_T2", in_ready, 1'b0);
    tick();
    check_bit("timing_ready_T3", in_ready, 1'b1);
    send_sub(u_frame[1]);
    send_sub(u_frame[2]);
    send_sub(u_frame[3]);
    check_bit("timing_ovalid_T1", out_valid, 1'b0);
    tick();
    check_bit("timing_ovalid_T2", out_valid, 1'b0);
    tick();
    check_bit("timing_ovalid_T3", out_valid, 1'b1);
    recv_frame(1'b0);
  endtask

  task automatic test_backpressure;
    int t;
    load_basic();
    exp_q.push_back(5'h1D);
    exp_q.push_back(5'h02);
    out_ready = 1'b0;
    send_frame();
    t = 0;
    while (!out_valid && t < TMO) begin
      tick();
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 5'h1D || out_last !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%0b data=%h last=%0b in_ready=%0b, expected 1 1d 0 0",
                 i, out_valid, out_data, out_last, in_ready);
      end
      tick();
    end
    recv_frame(1'b0);
  endtask

  task automatic test_reuse;
    load_basic();
    exp_q.push_back(5'h1D);
    exp_q.push_back(5'h02);
    send_frame();
    recv_frame(1'b0);
    for (int c = 0; c < KB; c++) u_frame[c] = '0;
    exp_q.push_back(5'h00);
    exp_q.push_back(5'h00);
    send_frame();
    recv_frame(1'b0);
  endtask

  task automatic test_mid_reset;
    load_basic();
    send_sub(u_frame[0]);
    send_sub(u_frame[1]);
    rst = 1'b1;
    tick();
    check_bit("midrst_in_ready0", in_ready, 1'b0);
    tick();
    check_bit("midrst_in_ready1", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    exp_q.push_back(5'h1D);
    exp_q.push_back(5'h02);
    send_frame();
    recv_frame(1'b0);
  endtask

  task automatic test_random;
    int v;
    for (int f = 0; f < 12; f++) begin
      for (int r = 0; r < MB; r++) begin
        for (int c = 0; c < KB; c++) begin
          v = $urandom_range(0, D);
          set_entry(r, c, (v == D) ? 255 : v);
        end
      end
      for (int c = 0; c < KB; c++) u_frame[c] = D'($urandom_range(0, (1 << D) - 1));
      push_model();
      send_frame();
      recv_frame(1'b1);
    end
    check_bit("random_tbl_err", tbl_err, 1'b0);
  endtask

  task automatic test_bad_entry;
    load_basic();
    set_entry(0, 0, 7);
    exp_q.push_back(5'h1C);
    exp_q.push_back(5'h02);
    send_sub(u_frame[0]);
    check_bit("bad_err_before_upd", tbl_err, 1'b0);
    tick();
    check_bit("bad_err_after_upd", tbl_err, 1'b1);
    send_sub(u_frame[1]);
    send_sub(u_frame[2]);
    send_sub(u_frame[3]);
    recv_frame(1'b0);
    load_basic();
    exp_q.push_back(5'h1D);
    exp_q.push_back(5'h02);
    send_frame();
    recv_frame(1'b0);
    check_bit("bad_err_sticky", tbl_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_bit("bad_err_cleared", tbl_err, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_backpressure();
    test_reuse();
    test_mid_reset();
    test_random();
    test_bad_entry();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: %0d entries remain, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
